// File: rtl/dac_threshold_sequencer_pkg.sv
// +--------------------------------------------------------------------------+
// | dac_threshold_sequencer_pkg : shared types and helpers for DAC sequencing |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

package dac_threshold_sequencer_pkg;

  localparam logic [3:0] c_CMD_WRITE_UPDATE = 4'h3;
  localparam logic [3:0] c_CMD_REF_SETUP    = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REF    = 3'd1,
    ST_SCAN   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  // Control byte exposed in the NIM+ parameter register map.
  typedef struct packed {
    logic [4:0] rsvd;
    logic       ref_en;
    logic       refresh_all;
    logic       apply;
  } dac_ctrl_t;

  function automatic logic [31:0] build_cmd(input logic [3:0]  cmd,
                                            input logic [3:0]  addr,
                                            input logic [11:0] data);
    return {4'h0, cmd, addr, data, 8'h00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_wait_timer.sv
// +--------------------------------------------------------------------------+
// | dac_wait_timer : loadable down-counter with zero flag                     |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module dac_wait_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/dac_threshold_sequencer.sv
// +--------------------------------------------------------------------------+
// | dac_threshold_sequencer : writes changed NIM threshold codes to the DAC   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module dac_threshold_sequencer
  import dac_threshold_sequencer_pkg::*;
#(
  parameter int         N_CH             = 8,
  parameter int         CODE_W           = 12,
  parameter int         WAIT_CYCLES      = 64,
  parameter logic [3:0] CMD_WRITE_UPDATE = c_CMD_WRITE_UPDATE,
  parameter logic [3:0] CMD_REF_SETUP    = c_CMD_REF_SETUP
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH*CODE_W-1:0]   thresh,
  input  logic                     apply,
  input  logic                     refresh_all,
  input  logic                     ref_en,
  output logic [31:0]              dac_data,
  output logic                     dac_wr_dac,
  output logic                     busy,
  output logic                     done,
  output logic [N_CH-1:0]          written_mask
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW   = $clog2(WAIT_CYCLES + 1);
  // The COMMIT cycle is part of the channel-to-channel gap, so that path waits one less.
  localparam logic [TW-1:0] c_WAIT_REF = TW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0] c_WAIT_CH  = TW'(WAIT_CYCLES - 2);

  function automatic logic [CH_W-1:0] lowest_set(input logic [N_CH-1:0] m);
    lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CH_W'(i);
    end
  endfunction

  state_t                        state_q, state_d;
  state_t                        target_q, target_d;
  logic [N_CH-1:0][CODE_W-1:0]   shadow_q;
  logic [N_CH-1:0][CODE_W-1:0]   last_q;
  logic [N_CH-1:0][CODE_W-1:0]   w_thresh;
  logic [N_CH-1:0]               dirty_q;
  logic [N_CH-1:0]               valid_q;
  logic [N_CH-1:0]               w_dirty_apply;
  logic                          pending_q, pending_all_q;
  logic [CH_W-1:0]               ch_q;
  logic [31:0]                   dac_data_q;
  logic                          dac_wr_q, busy_q, busy_d, done_q, done_d;

  logic                          w_req, w_found, w_tmr_zero;
  logic [CH_W-1:0]               w_sel;
  logic                          snap, snap_all, emit_ref, emit_ch, commit, tmr_load;
  logic [TW-1:0]                 tmr_val;

  assign w_thresh = thresh;
  assign w_req    = apply | refresh_all;
  assign w_found  = |dirty_q;
  assign w_sel    = lowest_set(dirty_q);

  always_comb begin
    w_dirty_apply = '0;
    for (int n = 0; n < N_CH; n++) begin
      w_dirty_apply[n] = !valid_q[n] || (w_thresh[n] != last_q[n]);
    end
  end

  dac_wait_timer #(.W(TW)) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (w_tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= ST_IDLE;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    snap     = 1'b0;
    snap_all = 1'b0;
    emit_ref = 1'b0;
    emit_ch  = 1'b0;
    commit   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = c_WAIT_REF;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req) begin
          snap     = 1'b1;
          snap_all = refresh_all;
          busy_d   = 1'b1;
          state_d  = ST_REF;
        end
      end
      ST_REF: begin
        emit_ref = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = c_WAIT_REF;
        target_d = ST_SCAN;
        state_d  = ST_WAIT;
      end
      ST_SCAN: begin
        if (w_found) begin
          emit_ch  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = c_WAIT_CH;
          target_d = ST_COMMIT;
          state_d  = ST_WAIT;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_WAIT: begin
        if (w_tmr_zero) state_d = target_q;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_SCAN;
      end
      ST_FIN: begin
        done_d = 1'b1;
        // A request landing in FIN is folded into the rerun snapshot.
        if (pending_q || w_req) begin
          snap     = 1'b1;
          snap_all = pending_all_q | refresh_all;
          state_d  = ST_REF;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q      <= '0;
      last_q        <= '0;
      dirty_q       <= '0;
      valid_q       <= '0;
      pending_q     <= 1'b0;
      pending_all_q <= 1'b0;
      ch_q          <= '0;
      dac_data_q    <= '0;
      dac_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      dac_wr_q <= emit_ref | emit_ch;
      if (snap) begin
        shadow_q <= w_thresh;
        dirty_q  <= snap_all ? {N_CH{1'b1}} : w_dirty_apply;
      end
      if (commit) begin
        last_q[ch_q]  <= shadow_q[ch_q];
        valid_q[ch_q] <= 1'b1;
        dirty_q[ch_q] <= 1'b0;
      end
      if (state_q == ST_FIN) begin
        pending_q     <= 1'b0;
        pending_all_q <= 1'b0;
      end else if (state_q != ST_IDLE && w_req) begin
        pending_q     <= 1'b1;
        pending_all_q <= pending_all_q | refresh_all;
      end
      if (emit_ref) begin
        dac_data_q <= build_cmd(CMD_REF_SETUP, 4'h0, 12'h000) | {31'b0, ref_en};
      end else if (emit_ch) begin
        ch_q       <= w_sel;
        dac_data_q <= build_cmd(CMD_WRITE_UPDATE, 4'(w_sel), 12'(shadow_q[w_sel]));
      end
    end
  end

  assign dac_data     = dac_data_q;
  assign dac_wr_dac   = dac_wr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign written_mask = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dac_threshold_sequencer.sv
// +--------------------------------------------------------------------------+
// | tb_dac_threshold_sequencer : directed self-checking bench                 |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dac_threshold_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [95:0] thresh = '0;
  logic        apply = 1'b0;
  logic        refresh_all = 1'b0;
  logic        ref_en = 1'b0;
  logic [31:0] dac_data;
  logic        dac_wr_dac;
  logic        busy;
  logic        done;
  logic [7:0]  written_mask;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;
  logic [31:0] words[$];
  int          times[$];
  logic [11:0] code[8];

  localparam logic [31:0] REF_ON  = 32'h08000001;
  localparam logic [31:0] REF_OFF = 32'h08000000;

  dac_threshold_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .thresh       (thresh),
    .apply        (apply),
    .refresh_all  (refresh_all),
    .ref_en       (ref_en),
    .dac_data     (dac_data),
    .dac_wr_dac   (dac_wr_dac),
    .busy         (busy),
    .done         (done),
    .written_mask (written_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (dac_wr_dac) begin
      words.push_back(dac_data);
      times.push_back(cyc);
    end
    if (done) done_cnt++;
    if (busy) busy_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch_word(input int n, input logic [11:0] c);
    return {4'h0, 4'h3, 4'(n), c, 8'h00};
  endfunction

  task automatic drive_thresh();
    for (int n = 0; n < 8; n++) thresh[n*12 +: 12] = code[n];
  endtask

  task automatic clear_log();
    words.delete();
    times.delete();
    done_cnt = 0;
    busy_cyc = 0;
  endtask

  task automatic pulse(input logic a, input logic r);
    @(negedge clk);
    apply = a;
    refresh_all = r;
    @(negedge clk);
    apply = 1'b0;
    refresh_all = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("sequence_timeout", {31'b0, busy}, 32'h0);
    @(negedge clk);
  endtask

  task automatic check_full(input string tag);
    check({tag, "_count"}, words.size(), 9);
    if (words.size() == 9) begin
      check({tag, "_ref"}, words[0], REF_ON);
      for (int n = 0; n < 8; n++) check($sformatf("%s_ch%0d", tag, n), words[n+1], ch_word(n, code[n]));
    end
  endtask

  initial begin
    int bad;
    for (int n = 0; n < 8; n++) code[n] = 12'h100 + 12'(n);
    repeat (3) @(negedge clk);
    check("rst_data", dac_data, 32'h0);
    check("rst_ctrl", {28'b0, dac_wr_dac, busy, done, 1'b0}, 32'h0);
    check("rst_mask", {24'b0, written_mask}, 32'h0);
    reset = 1'b0;

    // Initial programming of all channels
    drive_thresh();
    ref_en = 1'b1;
    clear_log();
    pulse(1'b1, 1'b0);
    wait_done();
    check_full("init");
    bad = 0;
    for (int i = 1; i < times.size(); i++) if (times[i] - times[i-1] != 65) bad++;
    check("init_spacing", bad, 0);
    check("init_done", done_cnt, 1);
    check("init_mask", {24'b0, written_mask}, 32'hFF);

    // Single changed channel
    code[5] = 12'hABC;
    drive_thresh();
    clear_log();
    pulse(1'b1, 1'b0);
    wait_done();
    check("ch5_count", words.size(), 2);
    if (words.size() == 2) begin
      check("ch5_ref", words[0], REF_ON);
      check("ch5_word", words[1], 32'h035ABC00);
      check("ch5_spacing", times[1] - times[0], 65);
    end
    check("ch5_done", done_cnt, 1);
    check("ch5_busy", {31'b0, busy}, 32'h0);

    // No change, reference disabled: reference word only
    ref_en = 1'b0;
    clear_log();
    pulse(1'b1, 1'b0);
    wait_done();
    check("nochg_count", words.size(), 1);
    if (words.size() == 1) check("nochg_ref", words[0], REF_OFF);
    check("nochg_done", done_cnt, 1);
    check("nochg_busy_cycles", busy_cyc, 67);
    check("nochg_mask", {24'b0, written_mask}, 32'hFF);
    ref_en = 1'b1;

    // Apply while busy: first run uses the old snapshot, rerun picks up ch2
    code[1] = 12'h222;
    drive_thresh();
    clear_log();
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    code[2] = 12'h7FF;
    drive_thresh();
    pulse(1'b1, 1'b0);
    wait_done();
    check("pend_count", words.size(), 4);
    if (words.size() == 4) begin
      check("pend_w0", words[0], REF_ON);
      check("pend_w1", words[1], 32'h03122200);
      check("pend_w2", words[2], REF_ON);
      check("pend_w3", words[3], 32'h0327FF00);
    end
    check("pend_done", done_cnt, 2);

    // refresh_all together with apply rewrites every channel
    clear_log();
    pulse(1'b1, 1'b1);
    wait_done();
    check_full("refresh");
    check("refresh_done", done_cnt, 1);

    // Pending refresh_all upgrades the rerun
    clear_log();
    pulse(1'b1, 1'b0);
    repeat (10) @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_done();
    check("pendall_count", words.size(), 10);
    if (words.size() == 10) begin
      check("pendall_ref2", words[1], REF_ON);
      check("pendall_ch7", words[9], ch_word(7, code[7]));
    end
    check("pendall_done", done_cnt, 2);

    // Reset in WAIT after the third strobe
    clear_log();
    pulse(1'b0, 1'b1);
    bad = 0;
    while (words.size() < 3 && bad < 1000) begin
      @(negedge clk);
      bad++;
    end
    check("rst3_reached", {31'b0, words.size() >= 3}, 32'h1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_data", dac_data, 32'h0);
    check("midrst_ctrl", {29'b0, dac_wr_dac, busy, done}, 32'h0);
    check("midrst_mask", {24'b0, written_mask}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    pulse(1'b1, 1'b0);
    wait_done();
    check_full("after_rst");
    check("after_rst_mask", {24'b0, written_mask}, 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dac_threshold_sequencer.md
Name: dac_threshold_sequencer

Overview:
- Configures the 8-channel NIM-threshold DAC. Software sets 12-bit per-channel threshold codes and an apply strobe. The block finds the channels that changed and issues one 32-bit DAC command per channel to the DAC serial controller (data word plus write-DAC pulse), respecting the controller's fixed transaction time.
- Sits between the AXI parameter registers and the DAC serial controller, on the DAC clock domain.
- Replaces direct software strobing of the DAC write bit.

Parameters:
- N_CH, 8, number of DAC channels (max 16).
- CODE_W, 12, threshold code width.
- WAIT_CYCLES, 64, clk cycles after each write pulse before the next command; must cover one full serial transaction.
- CMD_WRITE_UPDATE, 4'h3, DAC command nibble for write-and-update channel n.
- CMD_REF_SETUP, 4'h8, DAC command nibble for the internal reference setup.

Ports:
- clk  in  1  DAC-domain clock (single clock)
- reset  in  1  asynchronous, active-high reset
- thresh  in  N_CH*CODE_W  per-channel codes; channel n occupies bits [n*CODE_W +: CODE_W]
- apply  in  1  single-cycle pulse: snapshot thresh and write changed channels
- refresh_all  in  1  single-cycle pulse: snapshot thresh and write every channel
- ref_en  in  1  internal reference enable, sent as the first command of every sequence
- dac_data  out  32  command word to the DAC controller
- dac_wr_dac  out  1  single-cycle write strobe to the DAC controller
- busy  out  1  high while a sequence is running or pending
- done  out  1  single-cycle pulse when a sequence completes
- written_mask  out  N_CH  channels holding a valid written value since reset

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, shadow and last-written codes 0, dirty mask 0, valid mask 0, pending flag 0.
- Command word format: {4'h0, cmd[3:0], addr[3:0], data[11:0], 8'h00}.
  - Channel n: cmd=CMD_WRITE_UPDATE, addr=n, data=code.
  - Reference word: cmd=CMD_REF_SETUP, addr=0, data=0, LSB of word = ref_en.
- Trigger in IDLE: apply or refresh_all copies thresh into the shadow on the same edge.
  - Dirty mask: apply gives dirty[n] = !valid[n] || shadow[n] != last[n]; refresh_all gives all ones.
  - If apply and refresh_all arrive together, refresh_all wins.
- FSM states:
  - IDLE: on trigger go to REF. busy rises the cycle after the trigger.
  - REF: drive the reference word, pulse dac_wr_dac for 1 cycle, go to WAIT with target SCAN.
  - SCAN: pick the lowest-index dirty channel. If none, go to FIN. Otherwise drive its word, pulse dac_wr_dac, go to WAIT with target COMMIT.
  - WAIT: count WAIT_CYCLES cycles from the pulse, then go to the target state.
  - COMMIT: last[n] <= shadow[n], valid[n] <= 1, dirty[n] <= 0, go to SCAN.
  - FIN: pulse done. If pending, clear it, re-snapshot as an apply and go to REF; otherwise go to IDLE and drop busy.
- dac_data: holds its value from the strobe cycle until the next strobe. dac_wr_dac is never high two cycles in a row.
- Minimum spacing between strobes is WAIT_CYCLES+1 cycles.
- apply or refresh_all while not IDLE: sets pending. A pending refresh_all is remembered (pending_all) and upgrades the rerun to all ones. thresh changes mid-sequence never alter the words in flight.
- Apply with zero dirty channels: only the reference word is sent, then done. busy lasts exactly 1 + (WAIT_CYCLES+1) + a fixed small overhead.
- Reset mid-sequence: all state is aborted and valid is cleared, so the next apply rewrites every channel.
- A latched pending request is never dropped.

Decomposition:
- Shared package holds:
  - the command nibble constants
  - a function building the 32-bit command word from (cmd, addr, data)
  - the FSM state enum
  - the 8 bits of the parameter struct for thresh/apply/refresh_all/ref_en, added to the NIM+ register map
- Sub-module: dac_wait_timer. Loadable down-counter with a zero flag, reused wherever fixed spacing is needed.
- Lowest-set-bit priority encoder stays inline as a function.

Test Plan:
- After reset, thresh ch0..7 = 0x100..0x107, ref_en=1, apply pulse:
  - 9 strobes; first word 0x08000001, then 0x03010000 | (n<<20)... i.e. ch0 word 0x03010000, ch7 word 0x03710700
  - strobes spaced exactly 65 cycles apart
  - one done pulse; written_mask = 0xFF
- Change only ch5 to 0xABC, apply: exactly 2 strobes (reference word, then 0x035ABC00), done, busy low afterwards.
- apply with no changes: 1 strobe (reference only), done pulse, written_mask unchanged.
- apply while busy with ch2 changed to 0x7FF mid-sequence: the first sequence uses the old values; after done, a second sequence writes 0x0327FF00; two done pulses total.
- refresh_all with no changes, with simultaneous apply: 9 strobes covering all channels in order 0..7.
- Assert reset during WAIT after the 3rd strobe: outputs 0 immediately; next apply produces 9 strobes again.
